// File: rtl/dsp_goertzel_coeff_server.sv
// dsp_goertzel_coeff_server: trig responder returning one Q2.14 sin/cos pair per request for a programmable bin sequence
// Optional feature macro: GCS_BIN_TAG_EN adds bin_tag_out (phase index of the current response).
// Ports:
//   sys_clk, sys_rst              clock, synchronous active-high reset
//   request_trig                  1-cycle request for the next coefficient pair
//   trig_ready                    1-cycle pulse, sin_out/cos_out valid
//   sin_out, cos_out              signed Q2.14 sin/cos of 2*pi*p/512
//   cfg_start_bin/bin_step/num_bins  sequence start, increment, length (0 acts as 1)
//   seq_restart                   reload pointer to cfg_start_bin, clear count
//   busy                          request in flight
//   err_overrun                   sticky, request seen while busy
//   bin_tag_out                   (GCS_BIN_TAG_EN only) p of current response
module dsp_goertzel_coeff_server #(
  parameter int PH_BITS = 9
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               request_trig,
  output logic               trig_ready,
  output logic [15:0]        sin_out,
  output logic [15:0]        cos_out,
  input  logic [PH_BITS-1:0] cfg_start_bin,
  input  logic [PH_BITS-1:0] cfg_bin_step,
  input  logic [5:0]         cfg_num_bins,
  input  logic               seq_restart,
  output logic               busy,
  output logic               err_overrun
`ifdef GCS_BIN_TAG_EN
  ,
  output logic [PH_BITS-1:0] bin_tag_out
`endif
);
  localparam int QW = 1 << (PH_BITS - 2);
  localparam logic signed [127:0] PI60 = 128'sh3243F6A8885A308D;
  // Quarter-wave entry round(16384*sin(2*pi*a/2^PH_BITS)), evaluated at elaboration
  // with a 2^-60 fixed-point Taylor series so the table needs no external file.
  function automatic logic [15:0] qsin(input int a);
    logic signed [127:0] x, t, s;
    x = (128'(a) * PI60) >>> (PH_BITS - 1);
    t = x;
    s = x;
    for (int k = 1; k < 16; k++) begin
      t = (t * x) >>> 60;
      t = -((t * x) >>> 60) / 128'(2 * k * (2 * k + 1));
      s = s + t;
    end
    return 16'((s + (128'sd1 <<< 45)) >>> 46);
  endfunction
  // Odd quadrants read the table mirrored.
  function automatic logic [PH_BITS-2:0] raddr(input logic [PH_BITS-1:0] i);
    return i[PH_BITS-2] ? (PH_BITS-1)'(QW) - {1'b0, i[PH_BITS-3:0]} : {1'b0, i[PH_BITS-3:0]};
  endfunction
  logic [15:0] rom [QW+1];
  for (genvar g = 0; g <= QW; g++) begin : g_rom
    localparam logic [15:0] V = qsin(g);
    assign rom[g] = V;
  end
  typedef enum logic [1:0] {IDLE, ADDR, ROM, OUT} state_t;
  state_t state_q, state_d;
  logic [PH_BITS-1:0] ptr_q, ptr_d, p_q, pc;
  logic [5:0] cnt_q, cnt_d, cnt_inc, num;
  logic err_q, err_d, pend_q, pend_d, trig_q, wrap;
  logic [15:0] ms_q, mc_q, sin_q, cos_q;
  assign pc = p_q + PH_BITS'(QW);
  assign busy = state_q != IDLE;
  assign trig_ready = trig_q;
  assign sin_out = sin_q;
  assign cos_out = cos_q;
  assign err_overrun = err_q;
  always_comb begin
    state_d = state_q == IDLE ? (request_trig ? ADDR : IDLE) :
              state_q == ADDR ? ROM : state_q == ROM ? OUT : IDLE;
    num = cfg_num_bins == 6'd0 ? 6'd1 : cfg_num_bins;
    cnt_inc = cnt_q + 6'd1;
    // A restart seen mid-request is held until OUT so it overrides that advance.
    wrap = seq_restart | pend_q | (cnt_inc == num);
    err_d = ~seq_restart & (err_q | (request_trig & busy));
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    pend_d = pend_q | seq_restart;
    if (state_q == OUT) begin
      ptr_d = wrap ? cfg_start_bin : ptr_q + cfg_bin_step;
      cnt_d = wrap ? 6'd0 : cnt_inc;
      pend_d = 1'b0;
    end else if (state_q == IDLE && seq_restart) begin
      ptr_d = cfg_start_bin;
      cnt_d = 6'd0;
      pend_d = 1'b0;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ptr_q <= cfg_start_bin;
      cnt_q <= '0;
      err_q <= 1'b0;
      pend_q <= 1'b0;
      trig_q <= 1'b0;
      sin_q <= '0;
      cos_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      pend_q <= pend_d;
      trig_q <= state_q == OUT;
      if (state_q == OUT) begin
        sin_q <= p_q[PH_BITS-1] ? -ms_q : ms_q;
        cos_q <= pc[PH_BITS-1] ? -mc_q : mc_q;
      end
    end
  end
  always_ff @(posedge sys_clk) begin
    if (state_q == ADDR) p_q <= ptr_q;
    ms_q <= rom[raddr(p_q)];
    mc_q <= rom[raddr(pc)];
  end
`ifdef GCS_BIN_TAG_EN
  logic [PH_BITS-1:0] tag_q;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) tag_q <= '0;
    else if (state_q == OUT) tag_q <= p_q;
  end
  assign bin_tag_out = tag_q;
`endif
endmodule

// File: tb/tb_dsp_goertzel_coeff_server.sv
// tb_dsp_goertzel_coeff_server: scoreboard bench for dsp_goertzel_coeff_server
module tb_dsp_goertzel_coeff_server;
  logic sys_clk, sys_rst, request_trig, trig_ready, seq_restart, busy, err_overrun;
  logic [15:0] sin_out, cos_out;
  logic [8:0] cfg_start_bin, cfg_bin_step;
  logic [5:0] cfg_num_bins;
`ifdef GCS_BIN_TAG_EN
  logic [8:0] bin_tag_out;
`endif
  dsp_goertzel_coeff_server dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .request_trig(request_trig), .trig_ready(trig_ready),
    .sin_out(sin_out), .cos_out(cos_out), .cfg_start_bin(cfg_start_bin), .cfg_bin_step(cfg_bin_step),
    .cfg_num_bins(cfg_num_bins), .seq_restart(seq_restart), .busy(busy), .err_overrun(err_overrun)
`ifdef GCS_BIN_TAG_EN
    , .bin_tag_out(bin_tag_out)
`endif
  );
  typedef struct {logic [8:0] p; logic [15:0] s; logic [15:0] c; int at;} exp_t;
  exp_t exp_q[$];
  int total = 0, passed = 0, fails = 0, ecnt = 0, mcnt = 0;
  logic [8:0] mptr;
  logic [15:0] l_sin, l_cos;
  logic prev_tr = 1'b0;
  localparam real W = 2.0 * 3.14159265358979323846 / 512.0;
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) ecnt <= ecnt + 1;
  function automatic logic [15:0] q14(input real v);
    int r;
    r = v < 0.0 ? -$rtoi(-v + 0.5) : $rtoi(v + 0.5);
    return 16'(r);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic m_restart();
    mptr = cfg_start_bin;
    mcnt = 0;
  endtask
  task automatic req(input logic rs = 1'b0);
    exp_t e;
    if (rs) m_restart();
    e.p = mptr;
    e.s = q14(16384.0 * $sin(W * mptr));
    e.c = q14(16384.0 * $cos(W * mptr));
    e.at = ecnt + 4;
    exp_q.push_back(e);
    l_sin = e.s;
    l_cos = e.c;
    mcnt++;
    if (mcnt == ((cfg_num_bins == 0) ? 1 : int'(cfg_num_bins))) m_restart();
    else mptr = mptr + cfg_bin_step;
    request_trig = 1'b1;
    seq_restart = rs;
    cyc();
    request_trig = 1'b0;
    seq_restart = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 12) begin
      cyc();
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask
  task automatic restart(input int s, input int st, input int nb);
    cfg_start_bin = 9'(s);
    cfg_bin_step = 9'(st);
    cfg_num_bins = 6'(nb);
    seq_restart = 1'b1;
    cyc();
    seq_restart = 1'b0;
    m_restart();
  endtask
  always @(negedge sys_clk) begin
    if (trig_ready) begin
      chk("trig_gap", {31'b0, prev_tr}, 0);
      if (exp_q.size() == 0) chk("spurious_trig", {31'b0, trig_ready}, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("sin p=%0d", e.p), {16'b0, sin_out}, {16'b0, e.s});
        chk($sformatf("cos p=%0d", e.p), {16'b0, cos_out}, {16'b0, e.c});
        chk("latency", ecnt, e.at);
`ifdef GCS_BIN_TAG_EN
        chk("tag", {23'b0, bin_tag_out}, {23'b0, e.p});
`endif
      end
    end
    prev_tr = trig_ready;
  end
  initial begin
    sys_rst = 1'b1;
    request_trig = 1'b0;
    seq_restart = 1'b0;
    cfg_start_bin = 9'd0;
    cfg_bin_step = 9'd64;
    cfg_num_bins = 6'd8;
    cyc();
    cyc();
    sys_rst = 1'b0;
    m_restart();
    chk("rst_trig", {31'b0, trig_ready}, 0);
    chk("rst_sin", {16'b0, sin_out}, 0);
    chk("rst_cos", {16'b0, cos_out}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_err", {31'b0, err_overrun}, 0);
    req();
    chk("busy_inflight", {31'b0, busy}, 1);
    drain();
    for (int i = 1; i < 8; i++) begin
      req();
      drain();
    end
    chk("hold_sin", {16'b0, sin_out}, {16'b0, l_sin});
    chk("hold_cos", {16'b0, cos_out}, {16'b0, l_cos});
    req();
    cyc();
    cyc();
    cyc();
    req();
    drain();
    chk("b2b_no_err", {31'b0, err_overrun}, 0);
    req();
    drain();
    cyc();
    req();
    drain();
    restart(10, 3, 4);
    for (int i = 0; i < 5; i++) begin
      req();
      drain();
    end
    restart(500, 20, 3);
    for (int i = 0; i < 4; i++) begin
      req();
      drain();
    end
    req();
    request_trig = 1'b1;
    cyc();
    request_trig = 1'b0;
    drain();
    cyc();
    cyc();
    chk("overrun_set", {31'b0, err_overrun}, 1);
    restart(500, 20, 3);
    chk("overrun_clr", {31'b0, err_overrun}, 0);
    req();
    drain();
    req();
    cyc();
    sys_rst = 1'b1;
    exp_q.delete();
    cyc();
    sys_rst = 1'b0;
    m_restart();
    chk("abort_trig", {31'b0, trig_ready}, 0);
    chk("abort_sin", {16'b0, sin_out}, 0);
    chk("abort_cos", {16'b0, cos_out}, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    cyc();
    cyc();
    cyc();
    req();
    drain();
    cfg_start_bin = 9'd300;
    cfg_bin_step = 9'd7;
    cfg_num_bins = 6'd5;
    req(1'b1);
    drain();
    restart(200, 5, 10);
    req();
    seq_restart = 1'b1;
    cyc();
    seq_restart = 1'b0;
    m_restart();
    drain();
    req();
    drain();
    restart(77, 9, 0);
    req();
    drain();
    req();
    drain();
    cyc();
    cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
